// File: rtl/pztb_mem_request_port_if.sv
// Request/response and memory-port bundle for pztb_mem_request_port.
// The slave modport is the port driver's view; master is the agent/memory side.
interface pztb_mem_request_port_if #(
    parameter int DATAW = 32,
    parameter int ADDRW = 10,
    parameter int CNTW  = 3
);
    logic             i_req_valid;
    logic             o_req_ready;
    logic             i_req_write;
    logic [ADDRW-1:0] i_req_address;
    logic [DATAW-1:0] i_req_data;
    logic [DATAW-1:0] i_req_mask;

    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [DATAW-1:0] o_rsp_data;
    logic             o_rsp_error;

    logic             o_me;
    logic             o_we;
    logic [ADDRW-1:0] o_adr;
    logic [DATAW-1:0] o_d;
    logic [DATAW-1:0] o_wem;
    logic [DATAW-1:0] i_q;

    logic [CNTW-1:0]  o_outstanding;

    modport slave (
        input  i_req_valid,
        output o_req_ready,
        input  i_req_write,
        input  i_req_address,
        input  i_req_data,
        input  i_req_mask,
        output o_rsp_valid,
        input  i_rsp_ready,
        output o_rsp_data,
        output o_rsp_error,
        output o_me,
        output o_we,
        output o_adr,
        output o_d,
        output o_wem,
        input  i_q,
        output o_outstanding
    );

    modport master (
        output i_req_valid,
        input  o_req_ready,
        output i_req_write,
        output i_req_address,
        output i_req_data,
        output i_req_mask,
        input  o_rsp_valid,
        output i_rsp_ready,
        input  o_rsp_data,
        input  o_rsp_error,
        input  o_me,
        input  o_we,
        input  o_adr,
        input  o_d,
        input  o_wem,
        output i_q,
        input  o_outstanding
    );
endinterface

// File: rtl/pztb_mem_request_port.sv
// Request-side driver for one memory port: issues strobes, tracks reads
// through the fixed read latency and returns data via a credit-limited FIFO.
module pztb_mem_request_port #(
    parameter int DATAW        = 32,
    parameter int WORDW        = 1024,
    parameter int ADDRW        = $clog2(WORDW),
    parameter int READ_LATENCY = 1,
    parameter int RSP_DEPTH    = 4,
    parameter int CNTW         = $clog2(RSP_DEPTH + 1)
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    pztb_mem_request_port_if.slave bus
);

    localparam int PTRW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [ADDRW:0] WORD_LIM = (ADDRW + 1)'(WORDW);
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(RSP_DEPTH);
    localparam logic [PTRW-1:0] LAST_PTR = PTRW'(RSP_DEPTH - 1);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("READ_LATENCY must be in 1..4");
    end
    if (RSP_DEPTH < READ_LATENCY + 2) begin : g_bad_depth
        $error("RSP_DEPTH must be at least READ_LATENCY+2");
    end
    if (CNTW != $clog2(RSP_DEPTH + 1)) begin : g_bad_cntw
        $error("CNTW is derived from RSP_DEPTH and must not be overridden");
    end

    // Reset-release delay and credit state
    logic            rst_n_q;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    // Read-tracking pipeline, one stage per cycle of memory latency
    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] vld_d;
    logic [READ_LATENCY-1:0] err_q;
    logic [READ_LATENCY-1:0] err_d;

    // Response FIFO
    logic [DATAW-1:0] fifo_data_q [RSP_DEPTH];
    logic             fifo_err_q  [RSP_DEPTH];
    logic [PTRW-1:0]  wr_ptr_q;
    logic [PTRW-1:0]  wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q;
    logic [PTRW-1:0]  rd_ptr_d;
    logic [CNTW-1:0]  fcnt_q;
    logic [CNTW-1:0]  fcnt_d;

    logic             req_ready;
    logic             accept;
    logic             in_range;
    logic             rd_acc;
    logic             push;
    logic             push_err;
    logic [DATAW-1:0] push_data;
    logic             rsp_valid;
    logic             pop;
    logic             fifo_full;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + PTRW'(1);
    endfunction

    // Ready depends only on registered state so the agent sees no comb path
    assign req_ready = rst_n_q && (cnt_q < DEPTH_C);
    assign accept    = bus.i_req_valid && req_ready;
    assign in_range  = {1'b0, bus.i_req_address} < WORD_LIM;
    assign rd_acc    = accept && !bus.i_req_write;

    // Out-of-range requests never touch the memory
    assign bus.o_req_ready = req_ready;
    assign bus.o_me        = accept && in_range;
    assign bus.o_we        = accept && in_range && bus.i_req_write;
    assign bus.o_adr       = bus.i_req_address;
    assign bus.o_d         = bus.i_req_data;
    assign bus.o_wem       = bus.i_req_write ? bus.i_req_mask : '0;

    // Last tracking stage lines up with valid memory data
    assign push      = vld_q[READ_LATENCY-1];
    assign push_err  = err_q[READ_LATENCY-1];
    assign push_data = push_err ? '0 : bus.i_q;

    assign rsp_valid = (fcnt_q != '0);
    assign pop       = rsp_valid && bus.i_rsp_ready;
    assign fifo_full = (fcnt_q == DEPTH_C);

    assign bus.o_rsp_valid   = rsp_valid;
    assign bus.o_rsp_data    = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign bus.o_rsp_error   = rsp_valid && fifo_err_q[rd_ptr_q];
    assign bus.o_outstanding = cnt_q;

    // Shift accepted reads down the latency pipeline
    always_comb begin
        vld_d    = '0;
        err_d    = '0;
        vld_d[0] = rd_acc;
        err_d[0] = !in_range;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
        end
    end

    // Credits: reads take one on accept, return it on response pop
    always_comb begin
        cnt_d = cnt_q;
        unique case ({rd_acc, pop})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO pointer and occupancy update; push and pop may coincide
    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fcnt_d   = fcnt_q;
        unique case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + CNTW'(1);
            2'b01:   fcnt_d = fcnt_q - CNTW'(1);
            default: fcnt_d = fcnt_q;
        endcase
    end

    // Control state with synchronous reset; in-flight reads are dropped
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rst_n_q  <= 1'b0;
            cnt_q    <= '0;
            vld_q    <= '0;
            err_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            rst_n_q  <= 1'b1;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
        end
    end

    // FIFO storage needs no reset; occupancy gates its visibility
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_err_q[wr_ptr_q]  <= push_err;
        end
    end

    a_no_overflow: assert property (
        @(posedge i_clk) disable iff (!i_rst_n) !(push && fifo_full)
    );

    a_credit_limit: assert property (
        @(posedge i_clk) disable iff (!i_rst_n) cnt_q <= DEPTH_C
    );

endmodule

// File: tb/tb_pztb_mem_request_port.sv
// Scoreboard bench for pztb_mem_request_port with a behavioural memory
// and a reference model of expected responses and credit count.
module tb_pztb_mem_request_port;

    localparam int DATAW = 32;
    localparam int WORDW = 1000;
    localparam int ADDRW = 10;
    localparam int RL    = 1;
    localparam int DEPTH = 4;
    localparam int CNTW  = 3;

    typedef struct {
        logic [DATAW-1:0] data;
        logic             err;
        int               cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pztb_mem_request_port_if #(
        .DATAW(DATAW), .ADDRW(ADDRW), .CNTW(CNTW)
    ) bus ();

    pztb_mem_request_port #(
        .DATAW(DATAW), .WORDW(WORDW), .ADDRW(ADDRW),
        .READ_LATENCY(RL), .RSP_DEPTH(DEPTH), .CNTW(CNTW)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t",
                     name, act, req, $time);
        end
    endtask

    function automatic logic [DATAW-1:0] init_val(input int a);
        return (32'(a) * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    always @(posedge clk) cyc++;

    // Behavioural memory port: write at the enable edge, data RL cycles on
    logic [DATAW-1:0] mem_arr [int];
    logic [DATAW-1:0] q_pipe [RL];
    int mem_wr_cnt = 0;

    always @(posedge clk) begin : mem_model
        int a;
        logic [DATAW-1:0] cur;
        a = int'(bus.o_adr);
        cur = mem_arr.exists(a) ? mem_arr[a] : init_val(a);
        if (bus.o_me && bus.o_we) begin
            mem_arr[a] = (cur & ~bus.o_wem) | (bus.o_d & bus.o_wem);
            mem_wr_cnt++;
        end
        if (bus.o_me && !bus.o_we) q_pipe[0] <= cur;
        for (int i = 1; i < RL; i++) q_pipe[i] <= q_pipe[i-1];
    end

    assign bus.i_q = q_pipe[RL-1];

    // Reference model: memory contents, expected responses, credits
    logic [DATAW-1:0] ref_mem [int];
    int exp_out = 0;
    bit rq_m = 1'b0;

    always @(negedge clk) begin : ref_model
        bit acc, hs, inr, rd;
        int a;
        logic [DATAW-1:0] cur;
        check("req_ready", bus.o_req_ready, rq_m && (exp_out < DEPTH));
        check("outstanding", bus.o_outstanding, exp_out);
        acc = bus.i_req_valid && bus.o_req_ready;
        a   = int'(bus.i_req_address);
        inr = a < WORDW;
        rd  = acc && !bus.i_req_write;
        cur = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
        if (acc) begin
            check("me", bus.o_me, inr);
            check("we", bus.o_we, inr && bus.i_req_write);
            check("adr", bus.o_adr, bus.i_req_address);
            check("d", bus.o_d, bus.i_req_data);
            check("wem", bus.o_wem, bus.i_req_write ? bus.i_req_mask : 0);
            if (bus.i_req_write && inr)
                ref_mem[a] = (cur & ~bus.i_req_mask)
                           | (bus.i_req_data & bus.i_req_mask);
        end else begin
            check("me_idle", {bus.o_me, bus.o_we}, 2'b00);
        end
        hs = bus.o_rsp_valid && bus.i_rsp_ready;
        if (!rst_n) begin
            exp_q.delete();
            exp_out = 0;
        end else begin
            if (rd) exp_q.push_back('{inr ? cur : '0, !inr, cyc + 1});
            exp_out = exp_out + int'(rd) - int'(hs);
        end
        rq_m = rst_n;
    end

    // Response monitor: pops the scoreboard on every response handshake
    logic [DATAW-1:0] held_d;
    logic held_e;
    bit holding = 1'b0;

    always @(negedge clk) begin : rsp_mon
        exp_t e;
        if (!rst_n) begin
            holding = 1'b0;
        end else begin
            if (holding) begin
                check("hold_valid", bus.o_rsp_valid, 1'b1);
                check("hold_data", bus.o_rsp_data, held_d);
                check("hold_error", bus.o_rsp_error, held_e);
            end
            holding = 1'b0;
            if (bus.o_rsp_valid && bus.i_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", bus.o_rsp_data, e.data);
                    check("rsp_error", bus.o_rsp_error, e.err);
                    check("rsp_latency", (cyc + 1 - e.cyc) >= RL + 1, 1'b1);
                end
            end else if (bus.o_rsp_valid) begin
                holding = 1'b1;
                held_d  = bus.o_rsp_data;
                held_e  = bus.o_rsp_error;
            end
        end
    end

    task automatic send(input bit w, input int a,
                        input logic [DATAW-1:0] d, input logic [DATAW-1:0] m);
        bit ok;
        ok = 1'b0;
        bus.i_req_valid   = 1'b1;
        bus.i_req_write   = w;
        bus.i_req_address = ADDRW'(a);
        bus.i_req_data    = d;
        bus.i_req_mask    = m;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.o_req_ready;
        end
        if (!ok) check("send_timeout", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = (bus.o_outstanding == 0) && !bus.o_rsp_valid;
        end
        if (!ok) check("idle_timeout", 1'b1, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : driver
        int n_acc, w0;
        bit acc;
        bus.i_req_valid   = 1'b0;
        bus.i_req_write   = 1'b0;
        bus.i_req_address = '0;
        bus.i_req_data    = '0;
        bus.i_req_mask    = '0;
        bus.i_rsp_ready   = 1'b0;

        // Reset values and ready timing after release
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_cycle1", bus.o_req_ready, 1'b0);
        check("rst_rsp_valid", bus.o_rsp_valid, 1'b0);
        check("rst_rsp_error", bus.o_rsp_error, 1'b0);
        check("rst_rsp_data", bus.o_rsp_data, 0);
        check("rst_outstanding", bus.o_outstanding, 0);
        check("rst_me_we", {bus.o_me, bus.o_we}, 2'b00);
        step();
        check("ready_cycle2", bus.o_req_ready, 1'b1);

        // Single write then read with exact latency
        bus.i_rsp_ready = 1'b1;
        send(1'b1, 5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        send(1'b0, 5, '0, '0);
        check("rd_lat_early", bus.o_rsp_valid, 1'b0);
        step();
        check("rd_lat_due", bus.o_rsp_valid, 1'b1);
        check("rd_data_5", bus.o_rsp_data, 32'hDEAD_BEEF);
        wait_idle();

        // Masked write merges with old contents
        send(1'b1, 7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send(1'b1, 7, 32'h0000_0000, 32'h0000_FFFF);
        send(1'b0, 7, '0, '0);
        step();
        check("masked_data", bus.o_rsp_data, 32'hFFFF_0000);
        wait_idle();

        // Back-pressure fills exactly the credit limit
        bus.i_rsp_ready   = 1'b0;
        bus.i_req_valid   = 1'b1;
        bus.i_req_write   = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            bus.i_req_address = ADDRW'($urandom_range(WORDW - 1));
            @(negedge clk);
            acc = bus.o_req_ready;
            step();
            if (!acc) break;
            n_acc++;
        end
        bus.i_req_valid = 1'b0;
        check("bp_accepted", n_acc, DEPTH);
        check("bp_outstanding", bus.o_outstanding, DEPTH);
        repeat (3) step();
        bus.i_rsp_ready = 1'b1;
        wait_idle();
        check("bp_drained", bus.o_outstanding, 0);

        // Out-of-range reads and writes, plus both sides of the boundary
        send(1'b0, 1010, '0, '0);
        step();
        check("oor_rsp_data", bus.o_rsp_data, 0);
        check("oor_rsp_error", bus.o_rsp_error, 1'b1);
        wait_idle();
        w0 = mem_wr_cnt;
        send(1'b1, 1010, 32'h1234_5678, 32'hFFFF_FFFF);
        repeat (4) step();
        check("oor_no_write", mem_wr_cnt, w0);
        check("oor_no_rsp", bus.o_rsp_valid, 1'b0);
        send(1'b1, WORDW - 1, 32'hA5A5_5A5A, 32'hFFFF_FFFF);
        send(1'b0, WORDW - 1, '0, '0);
        send(1'b0, WORDW, '0, '0);
        wait_idle();

        // Reset with reads in flight and a response queued
        bus.i_rsp_ready = 1'b0;
        send(1'b0, 11, '0, '0);
        step();
        send(1'b0, 12, '0, '0);
        send(1'b0, 13, '0, '0);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        bus.i_rsp_ready = 1'b1;
        repeat (6) step();
        check("rst_mid_valid", bus.o_rsp_valid, 1'b0);
        check("rst_mid_outstanding", bus.o_outstanding, 0);
        send(1'b1, 3, 32'hCAFE_F00D, 32'hFFFF_FFFF);
        send(1'b0, 3, '0, '0);
        step();
        check("rst_mid_read", bus.o_rsp_data, 32'hCAFE_F00D);
        wait_idle();

        // Random traffic with random response back-pressure
        for (int i = 0; i < 400; i++) begin
            bus.i_req_valid = ($urandom_range(3) != 0);
            bus.i_req_write = $urandom_range(1) == 1;
            if ($urandom_range(7) == 0)
                bus.i_req_address = ADDRW'(WORDW + $urandom_range(23));
            else if ($urandom_range(2) == 0)
                bus.i_req_address = ADDRW'($urandom_range(7));
            else
                bus.i_req_address = ADDRW'($urandom_range(WORDW - 1));
            bus.i_req_data  = $urandom;
            bus.i_req_mask  = $urandom;
            bus.i_rsp_ready = ($urandom_range(3) != 0);
            step();
        end
        bus.i_req_valid = 1'b0;
        bus.i_rsp_ready = 1'b1;
        wait_idle();
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
